// File: rtl/neurex_mmu_pkg.sv
// neurex_mmu_pkg
//   Shared definitions for the MMU operand feeder.
//   - feeder_state_t : feeder FSM state encoding
//   - *_DEF          : default array geometry and operand width
//   - derived widths : total activation / weight bus widths, load-counter width
//   - cnt_bits()     : counter width able to index n items (minimum 1 bit)
package neurex_mmu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_FLUSH  = 2'd3
    } feeder_state_t;

    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SYS_ROW_DEF    = 16;
    localparam int SYS_COL_DEF    = 16;
    localparam int DATA_WIDTH_DEF = 16;

    localparam int ACT_WIDTH_DEF  = SYS_ROW_DEF * DATA_WIDTH_DEF;
    localparam int WGT_WIDTH_DEF  = SYS_COL_DEF * DATA_WIDTH_DEF;
    localparam int CNT_WIDTH_DEF  = cnt_bits(SYS_ROW_DEF);

endpackage

// File: rtl/sys_array_feeder_skew_line.sv
// skew_line
//   DEPTH-stage, WIDTH-bit shift register that advances every cycle.
//   DEPTH=0 degenerates to a plain wire.
// Ports:
//   clk  - clock
//   rstn - asynchronous active-low clear of every stage
//   din  - data into stage 0
//   dout - data out of the last stage (din when DEPTH=0)
module skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rstn;
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] taps_reg [DEPTH];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        taps_reg[i] <= '0;
                    end
                end else begin
                    taps_reg[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        taps_reg[i] <= taps_reg[i-1];
                    end
                end
            end

            assign dout = taps_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sys_array_feeder.sv
// sys_array_feeder
//   Feeds a weight-stationary systolic array: shifts SYS_ROW weight rows in
//   through the top of the array, then streams activation vectors through a
//   diagonal skew (row r delayed r cycles) and drains the skew with zeros.
//   Assumes SYS_ROW >= 2.
// Ports:
//   clk, rstn          - clock, asynchronous active-low reset
//   start              - begins a tile (ignored while busy)
//   w_keep             - only with SYS_FEEDER_WREUSE_EN: start skips LOAD
//   w_valid/w_ready    - weight-row handshake, w_data one row
//   a_valid/a_ready    - activation handshake, a_data one vector, a_last ends tile
//   busy, done         - status; done pulses once at end of FLUSH
//   arr_en             - valid token for array row 0
//   arr_w_wen/arr_w_in - per-column weight shift enable and weight row
//   arr_in             - skewed activations
// Configuration macro: SYS_FEEDER_WREUSE_EN (adds w_keep / weight reuse).
module sys_array_feeder
    import neurex_mmu_pkg::*;
#(
    parameter int SYS_ROW    = SYS_ROW_DEF,
    parameter int SYS_COL    = SYS_COL_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start,
`ifdef SYS_FEEDER_WREUSE_EN
    input  logic                          w_keep,
`endif
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [SYS_COL*DATA_WIDTH-1:0] w_data,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic [SYS_ROW*DATA_WIDTH-1:0] a_data,
    input  logic                          a_last,
    output logic                          busy,
    output logic                          done,
    output logic                          arr_en,
    output logic [SYS_COL-1:0]            arr_w_wen,
    output logic [SYS_COL*DATA_WIDTH-1:0] arr_w_in,
    output logic [SYS_ROW*DATA_WIDTH-1:0] arr_in
);

    localparam int ACT_W = SYS_ROW * DATA_WIDTH;
    localparam int WGT_W = SYS_COL * DATA_WIDTH;
    localparam int CNT_W = cnt_bits(SYS_ROW);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(SYS_ROW - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(SYS_ROW - 2);

    feeder_state_t     state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              done_reg, done_next;
    logic              keep;
    logic              w_fire, a_fire;

    logic [WGT_W-1:0]   w_in_reg;
    logic [SYS_COL-1:0] w_wen_reg;
    logic [ACT_W-1:0]   stage_reg;
    logic               tok_reg;

`ifdef SYS_FEEDER_WREUSE_EN
    assign keep = w_keep;
`else
    assign keep = 1'b0;
`endif

    assign w_fire = w_valid && w_ready;
    assign a_fire = a_valid && a_ready;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic. cnt_reg counts weight accepts in LOAD and elapsed
    // cycles in FLUSH.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // done_reg keeps busy high for one cycle after FLUSH, so a
                // start in that cycle is dropped.
                if (start && !done_reg) begin
                    state_next = keep ? ST_STREAM : ST_LOAD;
                    cnt_next   = '0;
                end
            end
            ST_LOAD: begin
                if (w_fire) begin
                    if (cnt_reg == LOAD_LAST) begin
                        cnt_next   = '0;
                        state_next = ST_STREAM;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if (a_fire && a_last) begin
                    cnt_next   = '0;
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (cnt_reg == FLUSH_LAST) begin
                    cnt_next   = '0;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_ready = (state_reg == ST_LOAD);
        a_ready = (state_reg == ST_STREAM);
        busy    = (state_reg != ST_IDLE) || done_reg;
        done    = done_reg;
    end

    // Weight path and skew input stage. Non-accept cycles load zeros with a
    // zero token, which both forms bubbles in STREAM and drains in FLUSH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_in_reg  <= '0;
            w_wen_reg <= '0;
            stage_reg <= '0;
            tok_reg   <= 1'b0;
        end else begin
            w_wen_reg <= {SYS_COL{w_fire}};
            if (w_fire) begin
                w_in_reg <= w_data;
            end
            stage_reg <= a_fire ? a_data : '0;
            tok_reg   <= a_fire;
        end
    end

    assign arr_w_wen = w_wen_reg;
    assign arr_w_in  = w_in_reg;
    assign arr_en    = tok_reg;

    // Row r gets r extra cycles of delay behind the input stage.
    genvar gi;
    generate
        for (gi = 0; gi < SYS_ROW; gi++) begin : g_row
            skew_line #(
                .DEPTH (gi),
                .WIDTH (DATA_WIDTH)
            ) u_skew (
                .clk  (clk),
                .rstn (rstn),
                .din  (stage_reg[gi*DATA_WIDTH +: DATA_WIDTH]),
                .dout (arr_in[gi*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

endmodule
